// File: rtl/dcm_sp_pkg.sv
// Shared widths, status bit positions and parameter-legality helper for dcm_sp.
package dcm_sp_pkg;

  localparam int ACC_W  = 6;
  localparam int LOCK_W = 8;

  localparam int ST_PARAM_ERR = 0;
  localparam int ST_RSVD1     = 1;
  localparam int ST_RSVD2     = 2;

  localparam int FX_MAX = 32;

  // M/D pair is usable only when 1 <= M <= D <= FX_MAX
  function automatic logic params_legal(input int m, input int d);
    return (m >= 1) && (m <= d) && (d <= FX_MAX);
  endfunction

endpackage

// File: rtl/frac_accum.sv
// Fractional-rate strobe generator: emits M one-cycle strobes every D enabled
// cycles using a modulo-D phase accumulator. Held at phase 0 while disabled.
module frac_accum
  import dcm_sp_pkg::*;
#(
  parameter int M = 25,
  parameter int D = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic             strobe,
  output logic [ACC_W-1:0] acc
);

  localparam logic [ACC_W-1:0] M_V = ACC_W'(M);
  localparam logic [ACC_W-1:0] D_V = ACC_W'(D);

  // acc < D <= 32 and M <= 32, so the sum never exceeds 63 for legal sets
  logic [ACC_W-1:0] sum;
  assign sum = acc + M_V;

  // Phase update: wrap by D and flag the wrap as a strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      strobe <= 1'b0;
    end else if (!en) begin
      acc    <= '0;
      strobe <= 1'b0;
    end else if (sum >= D_V) begin
      acc    <= sum - D_V;
      strobe <= 1'b1;
    end else begin
      acc    <= sum;
      strobe <= 1'b0;
    end
  end

endmodule

// File: rtl/dcm_sp.sv
// Behavioural clock-manager stand-in: CLK0 pass-through, lock timer and a
// fractional clock-enable strobe on CLKFX for pixel-rate logic to gate on.
module dcm_sp
  import dcm_sp_pkg::*;
#(
  parameter int CLKFX_MULTIPLY = 25,
  parameter int CLKFX_DIVIDE   = 32,
  parameter int LOCK_CYCLES    = 16
) (
  input  logic       CLKIN,
  input  logic       RST_N,
  input  logic       CLKFB,
  output logic       CLK0,
  output logic       CLKFX,
  output logic       LOCKED,
  output logic [2:0] STATUS
);

  localparam logic              LEGAL    = params_legal(CLKFX_MULTIPLY, CLKFX_DIVIDE);
  localparam logic [LOCK_W-1:0] LOCK_TGT = LOCK_W'(LOCK_CYCLES);

  logic [LOCK_W-1:0] lock_cnt;
  logic [ACC_W-1:0]  acc;

  // Feedback exists only for port compatibility with the vendor primitive
  logic unused_fb;
  assign unused_fb = CLKFB;

  assign CLK0 = CLKIN;

  always_comb begin
    STATUS               = '0;
    STATUS[ST_PARAM_ERR] = ~LEGAL;
    STATUS[ST_RSVD1]     = 1'b0;
    STATUS[ST_RSVD2]     = 1'b0;
  end

  // Lock timer: count up to LOCK_CYCLES, raise LOCKED on that edge, then hold
  always_ff @(posedge CLKIN or negedge RST_N) begin
    if (!RST_N) begin
      lock_cnt <= '0;
      LOCKED   <= 1'b0;
    end else if (LEGAL && (lock_cnt < LOCK_TGT)) begin
      lock_cnt <= lock_cnt + 1'b1;
      if (lock_cnt == LOCK_TGT - 1'b1)
        LOCKED <= 1'b1;
    end
  end

  frac_accum #(
    .M (CLKFX_MULTIPLY),
    .D (CLKFX_DIVIDE)
  ) u_fx (
    .clk    (CLKIN),
    .rst_n  (RST_N),
    .en     (LOCKED),
    .strobe (CLKFX),
    .acc    (acc)
  );

endmodule

// File: tb/tb_dcm_sp.sv
// Self-checking bench for dcm_sp: five parameterisations driven from one clock
// and reset, compared each cycle against an arithmetic model of the M/D rate,
// plus a table of hand-derived values and randomized mid-run resets.
module tb_dcm_sp;
  import dcm_sp_pkg::*;

  localparam int NI = 5;
  localparam int PM [NI] = '{25, 7, 1, 33, 5};
  localparam int PD [NI] = '{32, 7, 32, 32, 3};
  localparam int PL [NI] = '{16, 16, 4, 16, 16};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic fb = 1'b0;
  always #5 clk = ~clk;

  logic [NI-1:0] c0, fx, lk;
  logic [2:0]    st    [NI];
  logic [5:0]    acc_h [NI];

  dcm_sp #(.CLKFX_MULTIPLY(25), .CLKFX_DIVIDE(32), .LOCK_CYCLES(16)) d0 (
    .CLKIN(clk), .RST_N(rst_n), .CLKFB(fb), .CLK0(c0[0]), .CLKFX(fx[0]), .LOCKED(lk[0]), .STATUS(st[0]));
  dcm_sp #(.CLKFX_MULTIPLY(7), .CLKFX_DIVIDE(7), .LOCK_CYCLES(16)) d1 (
    .CLKIN(clk), .RST_N(rst_n), .CLKFB(fb), .CLK0(c0[1]), .CLKFX(fx[1]), .LOCKED(lk[1]), .STATUS(st[1]));
  dcm_sp #(.CLKFX_MULTIPLY(1), .CLKFX_DIVIDE(32), .LOCK_CYCLES(4)) d2 (
    .CLKIN(clk), .RST_N(rst_n), .CLKFB(fb), .CLK0(c0[2]), .CLKFX(fx[2]), .LOCKED(lk[2]), .STATUS(st[2]));
  dcm_sp #(.CLKFX_MULTIPLY(33), .CLKFX_DIVIDE(32), .LOCK_CYCLES(16)) d3 (
    .CLKIN(clk), .RST_N(rst_n), .CLKFB(fb), .CLK0(c0[3]), .CLKFX(fx[3]), .LOCKED(lk[3]), .STATUS(st[3]));
  dcm_sp #(.CLKFX_MULTIPLY(5), .CLKFX_DIVIDE(3), .LOCK_CYCLES(16)) d4 (
    .CLKIN(clk), .RST_N(rst_n), .CLKFB(fb), .CLK0(c0[4]), .CLKFX(fx[4]), .LOCKED(lk[4]), .STATUS(st[4]));

  assign acc_h[0] = d0.u_fx.acc;
  assign acc_h[1] = d1.u_fx.acc;
  assign acc_h[2] = d2.u_fx.acc;
  assign acc_h[3] = d3.u_fx.acc;
  assign acc_h[4] = d4.u_fx.acc;

  int pass_cnt = 0;
  int tot_cnt  = 0;
  int n        = 0;   // rising edges seen since the last reset release
  int cnt0     = 0;
  int cnt2     = 0;
  int rec_lk  [NI][256];
  int rec_fx  [NI][256];
  int rec_acc [NI][256];

  typedef struct {
    int inst;
    int edge_n;
    int lk;
    int fx;
    int acc;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp_v);
    tot_cnt++;
    if (act == exp_v) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
  endtask

  function automatic int legal_of(input int i);
    return (PM[i] >= 1 && PM[i] <= PD[i] && PD[i] <= 32) ? 1 : 0;
  endfunction

  // After k locked evaluations exactly floor(k*M/D) strobes have occurred,
  // so a strobe lands on edge k iff that floor steps; the phase is k*M mod D.
  function automatic void model(input int i, input int nn, output int elk, output int efx, output int eacc);
    int k;
    k    = nn - PL[i];
    elk  = (legal_of(i) != 0 && nn >= PL[i]) ? 1 : 0;
    efx  = 0;
    eacc = 0;
    if (legal_of(i) != 0 && k >= 1) begin
      efx  = ((k * PM[i]) / PD[i] != ((k - 1) * PM[i]) / PD[i]) ? 1 : 0;
      eacc = (k * PM[i]) % PD[i];
    end
  endfunction

  task automatic check_all(input string tag);
    int elk, efx, eacc;
    for (int i = 0; i < NI; i++) begin
      model(i, n, elk, efx, eacc);
      chk($sformatf("%s d%0d n=%0d LOCKED", tag, i, n), int'(lk[i]), elk);
      chk($sformatf("%s d%0d n=%0d CLKFX", tag, i, n), int'(fx[i]), efx);
      chk($sformatf("%s d%0d n=%0d acc", tag, i, n), int'(acc_h[i]), eacc);
      chk($sformatf("%s d%0d CLK0", tag, i), int'(c0[i]), int'(clk));
      chk($sformatf("%s d%0d STATUS", tag, i), int'(st[i]), legal_of(i) != 0 ? 0 : 1);
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    if (rst_n) n++;
    #1;
    check_all(tag);
    fb = 1'($urandom);
    if (n < 256) begin
      for (int i = 0; i < NI; i++) begin
        rec_lk[i][n]  = int'(lk[i]);
        rec_fx[i][n]  = int'(fx[i]);
        rec_acc[i][n] = int'(acc_h[i]);
      end
    end
    if (n >= 17 && n <= 80) cnt0 += int'(fx[0]);
    if (n >= 5 && n <= 68)  cnt2 += int'(fx[2]);
  endtask

  initial begin
    vec_t tbl [13];
    tbl = '{
      '{0, 1,  0, 0, 0},
      '{0, 15, 0, 0, 0},
      '{0, 16, 1, 0, 0},
      '{0, 17, 1, 0, 25},
      '{0, 18, 1, 1, 18},
      '{0, 19, 1, 1, 11},
      '{0, 20, 1, 1, 4},
      '{0, 21, 1, 0, 29},
      '{0, 22, 1, 1, 22},
      '{0, 48, 1, 1, 0},
      '{0, 80, 1, 1, 0},
      '{2, 35, 1, 0, 31},
      '{2, 36, 1, 1, 0}
    };

    // Reset held for five cycles
    rst_n = 1'b0;
    n     = 0;
    repeat (5) begin
      @(negedge clk);
      check_all("reset");
    end

    // First run: long enough for the 200-cycle illegal-parameter watch
    @(negedge clk);
    rst_n = 1'b1;
    n     = 0;
    repeat (230) step("run");
    chk("d0 strobes in 64 locked cycles", cnt0, 50);
    chk("d2 strobes in 64 locked cycles", cnt2, 2);

    for (int t = 0; t < 13; t++) begin
      chk($sformatf("tbl%0d d%0d edge %0d LOCKED", t, tbl[t].inst, tbl[t].edge_n),
          rec_lk[tbl[t].inst][tbl[t].edge_n], tbl[t].lk);
      chk($sformatf("tbl%0d d%0d edge %0d CLKFX", t, tbl[t].inst, tbl[t].edge_n),
          rec_fx[tbl[t].inst][tbl[t].edge_n], tbl[t].fx);
      chk($sformatf("tbl%0d d%0d edge %0d acc", t, tbl[t].inst, tbl[t].edge_n),
          rec_acc[tbl[t].inst][tbl[t].edge_n], tbl[t].acc);
    end

    // Randomized asynchronous resets landing mid-pattern
    repeat (4) begin
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      n = 0;
      check_all("async rst");
      repeat ($urandom_range(1, 3)) begin
        @(negedge clk);
        check_all("rst hold");
      end
      rst_n = 1'b1;
      repeat ($urandom_range(20, 90)) step("restart");
    end

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
